// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator shaft plant model.
// Contents:
//   - motor command encodings driven by the controller
//   - shaft state enum
//   - default floor count and a helper for floor-index width
package elevator_pkg;

    localparam int unsigned N_FLOORS_DEFAULT = 4;

    localparam logic [1:0] MOTOR_STOP    = 2'b00;
    localparam logic [1:0] MOTOR_UP      = 2'b01;
    localparam logic [1:0] MOTOR_DOWN    = 2'b10;
    localparam logic [1:0] MOTOR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        AT_FLOOR,
        MOVING,
        DOOR_OPEN,
        FAULT
    } shaft_state_e;

    // Width of a floor index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n_floors);
        return (n_floors > 1) ? $clog2(n_floors) : 1;
    endfunction

endpackage

// File: rtl/elevator_shaft_if.sv
// Motor-command / sensor interface between the elevator controller and the shaft.
// Optional macro: SHAFT_STATS_EN adds the trip and floors-passed counters.
// Signals:
//   estado_motor      2-bit motor command (controller -> shaft)
//   andar_sensor      one-hot aligned floor, zero between floors
//   andar_idx         index of last aligned floor
//   porta_aberta      door open
//   limit_hit         one-cycle pulse, drive refused at an end floor
//   cmd_viol          sticky, drive command seen while door open
//   fault             sticky, illegal command seen
//   viagens           (stats) door openings, saturating
//   andares_passados  (stats) floors passed under drive, saturating
// Modports: master = controller side, slave = shaft side.
interface elevator_shaft_if
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS = N_FLOORS_DEFAULT
);
    localparam int unsigned IDX_W = idx_width(N_FLOORS);

    logic [1:0]          estado_motor;
    logic [N_FLOORS-1:0] andar_sensor;
    logic [IDX_W-1:0]    andar_idx;
    logic                porta_aberta;
    logic                limit_hit;
    logic                cmd_viol;
    logic                fault;
`ifdef SHAFT_STATS_EN
    logic [15:0]         viagens;
    logic [15:0]         andares_passados;
`endif

    modport master (
        output estado_motor,
        input  andar_sensor,
        input  andar_idx,
        input  porta_aberta,
        input  limit_hit,
        input  cmd_viol,
`ifdef SHAFT_STATS_EN
        input  viagens,
        input  andares_passados,
`endif
        input  fault
    );

    modport slave (
        input  estado_motor,
        output andar_sensor,
        output andar_idx,
        output porta_aberta,
        output limit_hit,
        output cmd_viol,
`ifdef SHAFT_STATS_EN
        output viagens,
        output andares_passados,
`endif
        output fault
    );

endinterface

// File: rtl/door_timer.sv
// Door dwell timer: loads DOOR_CYCLES on i_load and pulses o_done in the
// DOOR_CYCLES-th cycle after the load, i.e. the cycle in which the door closes.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   i_load  start a new dwell period
//   o_done  combinational pulse on the last cycle of the dwell
module door_timer #(
    parameter int unsigned DOOR_CYCLES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);
    localparam int unsigned CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= CNT_LOAD;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/elevator_shaft.sv
// Plant model of an elevator car in its shaft. Integrates the motor command into
// a sub-floor position and reports floor alignment and door state back to the
// controller.
// Optional macro: SHAFT_STATS_EN adds the viagens / andares_passados counters.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   bus       elevator_shaft_if slave: estado_motor in, sensors/flags out
module elevator_shaft
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS      = N_FLOORS_DEFAULT,
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 6,
    parameter int unsigned START_FLOOR   = 0
) (
    input  logic             clk,
    input  logic             rst,
    elevator_shaft_if.slave  bus
);
    localparam int unsigned IDX_W = idx_width(N_FLOORS);
    localparam int unsigned SUB_W = $clog2(TRAVEL_CYCLES);

    localparam logic [IDX_W-1:0]    IDX_START    = IDX_W'(START_FLOOR);
    localparam logic [IDX_W-1:0]    IDX_TOP      = IDX_W'(N_FLOORS - 1);
    localparam logic [SUB_W-1:0]    SUB_LAST     = SUB_W'(TRAVEL_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] SENSOR_START = N_FLOORS'(1) << START_FLOOR;

    // Position is kept as (floor below the car, offset above it):
    // pos = r_lo * TRAVEL_CYCLES + r_sub. Aligned means r_sub == 0.
    shaft_state_e        r_state;
    logic [IDX_W-1:0]    r_lo;
    logic [SUB_W-1:0]    r_sub;
    logic [N_FLOORS-1:0] r_sensor;
    logic [IDX_W-1:0]    r_idx;
    logic                r_door;
    logic                r_limit;
    logic                r_viol;
    logic                r_fault;

    logic                w_aligned;
    logic                w_drive_ok;
    logic                w_step_up;
    logic                w_step_dn;
    logic                w_refuse;
    logic                w_stop_at_floor;
    logic                w_door_done;
    logic [IDX_W-1:0]    w_lo_nxt;
    logic [SUB_W-1:0]    w_sub_nxt;
    logic [N_FLOORS-1:0] w_sensor_nxt;

    assign w_aligned  = (r_sub == '0);
    assign w_drive_ok = (r_state == AT_FLOOR) || (r_state == MOVING);

    assign w_step_up = w_drive_ok && (bus.estado_motor == MOTOR_UP)
                       && !(w_aligned && (r_lo == IDX_TOP));
    assign w_step_dn = w_drive_ok && (bus.estado_motor == MOTOR_DOWN)
                       && !(w_aligned && (r_lo == '0));
    assign w_refuse  = w_drive_ok && !w_step_up && !w_step_dn
                       && ((bus.estado_motor == MOTOR_UP) || (bus.estado_motor == MOTOR_DOWN));

    assign w_stop_at_floor = (r_state == MOVING) && (bus.estado_motor == MOTOR_STOP)
                             && w_aligned;

    always_comb begin
        w_lo_nxt  = r_lo;
        w_sub_nxt = r_sub;
        if (w_step_up) begin
            if (r_sub == SUB_LAST) begin
                w_lo_nxt  = r_lo + 1'b1;
                w_sub_nxt = '0;
            end else begin
                w_sub_nxt = r_sub + 1'b1;
            end
        end else if (w_step_dn) begin
            if (r_sub == '0) begin
                w_lo_nxt  = r_lo - 1'b1;
                w_sub_nxt = SUB_LAST;
            end else begin
                w_sub_nxt = r_sub - 1'b1;
            end
        end
        w_sensor_nxt = (w_sub_nxt == '0) ? (N_FLOORS'(1) << w_lo_nxt) : '0;
    end

    door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_stop_at_floor),
        .o_done (w_door_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= AT_FLOOR;
            r_lo     <= IDX_START;
            r_sub    <= '0;
            r_sensor <= SENSOR_START;
            r_idx    <= IDX_START;
            r_door   <= 1'b0;
            r_limit  <= 1'b0;
            r_viol   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_limit <= 1'b0;
            if (r_state == FAULT) begin
                // Frozen until reset.
                r_state <= FAULT;
            end else if (bus.estado_motor == MOTOR_ILLEGAL) begin
                // Illegal command outranks every other event this cycle.
                r_state <= FAULT;
                r_fault <= 1'b1;
            end else begin
                r_lo     <= w_lo_nxt;
                r_sub    <= w_sub_nxt;
                r_sensor <= w_sensor_nxt;
                if (w_sub_nxt == '0) begin
                    r_idx <= w_lo_nxt;
                end
                unique case (r_state)
                    AT_FLOOR, MOVING: begin
                        r_limit <= w_refuse;
                        if (w_step_up || w_step_dn) begin
                            r_state <= MOVING;
                        end else if (w_stop_at_floor) begin
                            r_state <= DOOR_OPEN;
                            r_door  <= 1'b1;
                        end
                    end
                    DOOR_OPEN: begin
                        if (bus.estado_motor != MOTOR_STOP) begin
                            r_viol <= 1'b1;
                        end
                        if (w_door_done) begin
                            r_state <= AT_FLOOR;
                            r_door  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.andar_sensor = r_sensor;
    assign bus.andar_idx    = r_idx;
    assign bus.porta_aberta = r_door;
    assign bus.limit_hit    = r_limit;
    assign bus.cmd_viol     = r_viol;
    assign bus.fault        = r_fault;

`ifdef SHAFT_STATS_EN
    logic [15:0] r_trips;
    logic [15:0] r_passed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trips  <= '0;
            r_passed <= '0;
        end else if (r_state != FAULT && bus.estado_motor != MOTOR_ILLEGAL) begin
            if (w_stop_at_floor && (r_trips != 16'hFFFF)) begin
                r_trips <= r_trips + 16'd1;
            end
            // A floor counts as passed when the car leaves it while still in motion.
            if ((r_state == MOVING) && w_aligned && (w_step_up || w_step_dn)
                && (r_passed != 16'hFFFF)) begin
                r_passed <= r_passed + 16'd1;
            end
        end
    end

    assign bus.viagens          = r_trips;
    assign bus.andares_passados = r_passed;
`endif

endmodule

// File: tb/tb_elevator_shaft.sv
// Bench for elevator_shaft: two cars (start floor 0 and start floor 3) share one
// command stream; a behavioural model of the shaft predicts outputs per cycle,
// expectations are queued on drive and popped after the clock edge.
module tb_elevator_shaft;
    import elevator_pkg::*;

    localparam int N = 4;
    localparam int T = 8;
    localparam int D = 6;
    localparam int TOP_POS = (N - 1) * T;

    localparam int S_AT   = 0;
    localparam int S_MOV  = 1;
    localparam int S_DOOR = 2;
    localparam int S_FLT  = 3;

    typedef struct {
        int             pos;
        int             st;
        int             idx;
        logic [N-1:0]   sensor;
        bit             door;
        bit             limit;
        bit             viol;
        bit             fault;
        int             dcnt;
        int             trips;
        int             passed;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd;
    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    mdl_t       ma, mb;
    mdl_t       q_a[$];
    mdl_t       q_b[$];

    always #5 clk = ~clk;

    elevator_shaft_if #(.N_FLOORS(N)) bus_a ();
    elevator_shaft_if #(.N_FLOORS(N)) bus_b ();

    assign bus_a.estado_motor = cmd;
    assign bus_b.estado_motor = cmd;

    elevator_shaft #(
        .N_FLOORS      (N),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D),
        .START_FLOOR   (0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    elevator_shaft #(
        .N_FLOORS      (N),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D),
        .START_FLOOR   (3)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic mdl_t mdl_reset(input int start);
        mdl_t m;
        m.pos    = start * T;
        m.st     = S_AT;
        m.idx    = start;
        m.sensor = '0;
        m.sensor[start] = 1'b1;
        m.door   = 0;
        m.limit  = 0;
        m.viol   = 0;
        m.fault  = 0;
        m.dcnt   = 0;
        m.trips  = 0;
        m.passed = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input logic [1:0] c);
        mdl_t n = m;
        bit   al;
        n.limit = 0;
        if (m.st == S_FLT) return n;
        if (c == MOTOR_ILLEGAL) begin
            n.st    = S_FLT;
            n.fault = 1;
            return n;
        end
        al = (m.pos % T) == 0;
        if (m.st == S_AT || m.st == S_MOV) begin
            if (c == MOTOR_UP) begin
                if (m.pos == TOP_POS) begin
                    n.limit = 1;
                end else begin
                    if (m.st == S_MOV && al) n.passed = sat16(m.passed);
                    n.pos = m.pos + 1;
                    n.st  = S_MOV;
                end
            end else if (c == MOTOR_DOWN) begin
                if (m.pos == 0) begin
                    n.limit = 1;
                end else begin
                    if (m.st == S_MOV && al) n.passed = sat16(m.passed);
                    n.pos = m.pos - 1;
                    n.st  = S_MOV;
                end
            end else if (m.st == S_MOV && al) begin
                n.st    = S_DOOR;
                n.door  = 1;
                n.dcnt  = D;
                n.trips = sat16(m.trips);
            end
        end else begin
            if (c != MOTOR_STOP) n.viol = 1;
            n.dcnt = m.dcnt - 1;
            if (n.dcnt == 0) begin
                n.st   = S_AT;
                n.door = 0;
            end
        end
        n.sensor = '0;
        if ((n.pos % T) == 0) begin
            n.sensor[n.pos / T] = 1'b1;
            n.idx = n.pos / T;
        end
        return n;
    endfunction

    task automatic cmp_car(input string who, input mdl_t e, input logic [N-1:0] sensor,
                           input logic [1:0] idx, input logic door, input logic limit,
                           input logic viol, input logic fault,
                           input logic [15:0] trips, input logic [15:0] passed);
        check_val({who, ".sensor"}, 32'(sensor), 32'(e.sensor));
        check_val({who, ".idx"},    32'(idx),    32'(e.idx));
        check_val({who, ".door"},   32'(door),   32'(e.door));
        check_val({who, ".limit"},  32'(limit),  32'(e.limit));
        check_val({who, ".viol"},   32'(viol),   32'(e.viol));
        check_val({who, ".fault"},  32'(fault),  32'(e.fault));
`ifdef SHAFT_STATS_EN
        check_val({who, ".viagens"}, 32'(trips),  32'(e.trips));
        check_val({who, ".passed"},  32'(passed), 32'(e.passed));
`else
        if (trips != passed) begin
            $display("note: stats inputs differ while stats disabled");
        end
`endif
    endtask

    // Drive one cycle of stimulus, queue expectations, compare after the edge.
    task automatic step(input logic [1:0] c, input bit r);
        logic [15:0] a_tr, a_pa, b_tr, b_pa;
        cmd = c;
        rst = r;
        if (r) begin
            ma = mdl_reset(0);
            mb = mdl_reset(3);
        end else begin
            ma = mdl_next(ma, c);
            mb = mdl_next(mb, c);
        end
        q_a.push_back(ma);
        q_b.push_back(mb);
        @(posedge clk);
        #1;
        cyc++;
`ifdef SHAFT_STATS_EN
        a_tr = bus_a.viagens;
        a_pa = bus_a.andares_passados;
        b_tr = bus_b.viagens;
        b_pa = bus_b.andares_passados;
`else
        a_tr = '0; a_pa = '0; b_tr = '0; b_pa = '0;
`endif
        cmp_car("a", q_a.pop_front(), bus_a.andar_sensor, bus_a.andar_idx, bus_a.porta_aberta,
                bus_a.limit_hit, bus_a.cmd_viol, bus_a.fault, a_tr, a_pa);
        cmp_car("b", q_b.pop_front(), bus_b.andar_sensor, bus_b.andar_idx, bus_b.porta_aberta,
                bus_b.limit_hit, bus_b.cmd_viol, bus_b.fault, b_tr, b_pa);
    endtask

    task automatic repeat_cmd(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) step(c, 1'b0);
    endtask

    initial begin
        int door_len;
        int r;
        cmd = MOTOR_STOP;
        rst = 1'b1;
        #1;

        // Run up one floor from 0 and stop; car b sits at the top and is refused.
        step(MOTOR_STOP, 1'b1);
        step(MOTOR_STOP, 1'b1);
        repeat_cmd(MOTOR_UP, 7);
        check_val("t1.between_floors", 32'(bus_a.andar_sensor), 32'b0000);
        step(MOTOR_UP, 1'b0);
        check_val("t1.arrive_floor1", 32'(bus_a.andar_sensor), 32'b0010);
        check_val("t2.top_limit", 32'(bus_b.limit_hit), 32'd1);
        door_len = 0;
        for (int i = 0; i < 8; i++) begin
            step(MOTOR_STOP, 1'b0);
            if (bus_a.porta_aberta) door_len++;
        end
        check_val("t1.door_len", 32'(door_len), 32'(D));

        // Up 3, down 3, stop: door opens at floor 0. Then stop between floors.
        step(MOTOR_STOP, 1'b1);
        repeat_cmd(MOTOR_UP, 3);
        repeat_cmd(MOTOR_DOWN, 3);
        step(MOTOR_STOP, 1'b0);
        check_val("t3.door_at_0", 32'(bus_a.porta_aberta), 32'd1);
        repeat_cmd(MOTOR_STOP, 7);
        repeat_cmd(MOTOR_UP, 3);
        repeat_cmd(MOTOR_DOWN, 2);
        repeat_cmd(MOTOR_STOP, 4);
        check_val("t3.hold_no_door", 32'(bus_a.porta_aberta), 32'd0);

        // Continuous drive through floor 1 to floor 2.
        step(MOTOR_STOP, 1'b1);
        repeat_cmd(MOTOR_UP, 16);
        check_val("t4.floor2", 32'(bus_a.andar_sensor), 32'b0100);
        repeat_cmd(MOTOR_STOP, 8);

        // Drive commands while the door is open.
        step(MOTOR_STOP, 1'b1);
        repeat_cmd(MOTOR_UP, 8);
        step(MOTOR_STOP, 1'b0);
        repeat_cmd(MOTOR_DOWN, 3);
        check_val("t5.viol", 32'(bus_a.cmd_viol), 32'd1);
        repeat_cmd(MOTOR_STOP, 3);
        repeat_cmd(MOTOR_DOWN, 3);

        // Illegal command mid-travel, then reset.
        step(MOTOR_STOP, 1'b1);
        repeat_cmd(MOTOR_UP, 3);
        step(MOTOR_ILLEGAL, 1'b0);
        repeat_cmd(MOTOR_UP, 3);
        repeat_cmd(MOTOR_DOWN, 2);
        step(MOTOR_STOP, 1'b1);
        check_val("t6.fault_cleared", 32'(bus_a.fault), 32'd0);

        // Random traffic with occasional resets and illegal commands.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) step(MOTOR_STOP, 1'b1);
            else if (r < 3) step(MOTOR_ILLEGAL, 1'b0);
            else if (r < 40) step(MOTOR_UP, 1'b0);
            else if (r < 75) step(MOTOR_DOWN, 1'b0);
            else step(MOTOR_STOP, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
